// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters plus a return-address stack.
// Lookup is combinational on pre-update state; training happens from the branch unit's resolved outputs.
package branch_predictor_pkg;
  typedef enum logic [1:0] {CFLOW_PCPLUS4, CFLOW_BRANCH, CFLOW_JAL, CFLOW_JALR} cflow_mode_t;
  typedef enum logic [1:0] {CFHINT_NONE, CFHINT_CALL, CFHINT_RET} cflow_hint_t;
  typedef enum logic [1:0] {KIND_BR = 2'd0, KIND_JMP = 2'd1, KIND_RET = 2'd2} btb_kind_t;
endpackage

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pc_pred,
  input  logic [31:0] upd_pc,
  input  cflow_mode_t cflow_mode,
  input  cflow_hint_t cflow_hint,
  input  logic        cflow_taken,
  input  logic [31:0] pc_jump,
  input  logic        mispredict,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int RW    = $clog2(RAS_DEPTH);
  localparam int TAG_W = 30 - IDX;
  localparam logic [RW-1:0] RAS_ONE  = RW'(1);
  localparam logic [RW:0]   RAS_FULL = (RW+1)'(RAS_DEPTH);

  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
  logic [31:0]            target_mem [BTB_ENTRIES];
  btb_kind_t              kind_mem   [BTB_ENTRIES];
  logic [1:0]             ctr_mem    [BTB_ENTRIES];
  logic [31:0]            ras        [RAS_DEPTH];
  logic [RW-1:0]          ras_ptr;
  logic [RW:0]            ras_count;

  // Lookup path
  logic [IDX-1:0] l_idx;
  logic           l_hit;
  logic [31:0]    ras_top;

  assign l_idx   = if_pc[IDX+1:2];
  assign l_hit   = valid[l_idx] && (tag_mem[l_idx] == if_pc[31:IDX+2]);
  assign ras_top = ras[ras_ptr - RAS_ONE];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    pred_taken = 1'b0;
    pc_pred    = if_pc + 32'd4;
    if (l_hit) begin
      case (kind_mem[l_idx])
        KIND_BR: if (ctr_mem[l_idx][1]) begin
          pred_taken = 1'b1;
          pc_pred    = target_mem[l_idx];
        end
        KIND_JMP: begin
          pred_taken = 1'b1;
          pc_pred    = target_mem[l_idx];
        end
        KIND_RET: if (ras_count != '0) begin
          pred_taken = 1'b1;
          pc_pred    = ras_top;
        end
        default: ;
      endcase
    end
  end

  // Update path
  logic           upd;
  logic [IDX-1:0] u_idx;
  logic           u_hit;
  btb_kind_t      u_kind;
  logic [1:0]     u_ctr_old;
  logic [1:0]     u_ctr_new;
  logic           btb_wr;
  logic           ras_push;
  logic           ras_pop;

  assign upd       = (cflow_mode != CFLOW_PCPLUS4);
  assign u_idx     = upd_pc[IDX+1:2];
  assign u_hit     = valid[u_idx] && (tag_mem[u_idx] == upd_pc[31:IDX+2]);
  assign u_ctr_old = ctr_mem[u_idx];
  assign btb_wr    = upd && !rst && (cflow_taken || u_hit);
  assign ras_push  = upd && (cflow_hint == CFHINT_CALL);
  assign ras_pop   = upd && (cflow_hint == CFHINT_RET) && (ras_count != '0);

  always_comb begin
    u_kind = KIND_JMP;
    case (cflow_mode)
      CFLOW_BRANCH: u_kind = KIND_BR;
      CFLOW_JALR:   u_kind = (cflow_hint == CFHINT_RET) ? KIND_RET : KIND_JMP;
      default:      u_kind = KIND_JMP;
    endcase
  end

  always_comb begin
    u_ctr_new = u_ctr_old;
    if (cflow_taken) begin
      if (u_kind != KIND_BR)  u_ctr_new = 2'b11;
      else if (!u_hit)        u_ctr_new = 2'b10;
      else if (u_ctr_old != 2'b11) u_ctr_new = u_ctr_old + 2'd1;
    end else if (u_ctr_old != 2'b00) begin
      u_ctr_new = u_ctr_old - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (upd && cflow_taken) valid[u_idx] <= 1'b1;
  end

  // NOTE: table payloads carry no reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      ctr_mem[u_idx] <= u_ctr_new;
      if (cflow_taken) begin
        tag_mem[u_idx]    <= upd_pc[31:IDX+2];
        target_mem[u_idx] <= pc_jump;
        kind_mem[u_idx]   <= u_kind;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ras_push) ras[ras_ptr] <= upd_pc + 32'd4;
  end

  // Overflow keeps count saturated while the pointer wraps over the oldest slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + RAS_ONE;
      if (ras_count != RAS_FULL) ras_count <= ras_count + 1'b1;
    end else if (ras_pop) begin
      ras_ptr   <= ras_ptr - RAS_ONE;
      ras_count <= ras_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd) begin
      perf_branches <= perf_branches + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic,
// compared every cycle against a table/queue reference model of the predictor.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int BTB_ENTRIES = 64;
  localparam int RAS_DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pc_pred;
  logic [31:0] upd_pc;
  cflow_mode_t cflow_mode;
  cflow_hint_t cflow_hint;
  logic        cflow_taken;
  logic [31:0] pc_jump;
  logic        mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_ENTRIES(BTB_ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pc_pred(pc_pred),
    .upd_pc(upd_pc), .cflow_mode(cflow_mode), .cflow_hint(cflow_hint),
    .cflow_taken(cflow_taken), .pc_jump(pc_jump), .mispredict(mispredict),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  // Reference model: kind 0=BR, 1=JMP, 2=RET; RAS is a queue whose back is the top.
  typedef struct {
    bit        valid;
    bit [31:0] tag;
    bit [31:0] target;
    int        kind;
    int        ctr;
  } ent_t;

  ent_t      m_btb [BTB_ENTRIES];
  bit [31:0] m_ras [$];
  bit [31:0] m_branches;
  bit [31:0] m_mispredicts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_index(input bit [31:0] pc);
    return int'((pc >> 2) % BTB_ENTRIES);
  endfunction

  function automatic bit [31:0] m_tag(input bit [31:0] pc);
    return pc / (4 * BTB_ENTRIES);
  endfunction

  function automatic void m_predict(input bit [31:0] pc, output bit tk, output bit [31:0] np);
    int i = m_index(pc);
    tk = 1'b0;
    np = pc + 32'd4;
    if (m_btb[i].valid && m_btb[i].tag == m_tag(pc)) begin
      if (m_btb[i].kind == 2) begin
        if (m_ras.size() > 0) begin
          tk = 1'b1;
          np = m_ras[$];
        end
      end else if (m_btb[i].kind == 1 || m_btb[i].ctr >= 2) begin
        tk = 1'b1;
        np = m_btb[i].target;
      end
    end
  endfunction

  function automatic void m_reset();
    foreach (m_btb[i]) m_btb[i].valid = 1'b0;
    m_ras.delete();
    m_branches    = '0;
    m_mispredicts = '0;
  endfunction

  function automatic void m_update();
    int  i;
    int  k;
    bit  hit;
    if (rst) begin
      m_reset();
      return;
    end
    if (cflow_mode == CFLOW_PCPLUS4) return;
    i   = m_index(upd_pc);
    hit = m_btb[i].valid && m_btb[i].tag == m_tag(upd_pc);
    if (cflow_mode == CFLOW_BRANCH) k = 0;
    else if (cflow_mode == CFLOW_JALR && cflow_hint == CFHINT_RET) k = 2;
    else k = 1;
    if (cflow_taken) begin
      if (!hit) m_btb[i].ctr = (k == 0) ? 2 : 3;
      else      m_btb[i].ctr = (k == 0) ? ((m_btb[i].ctr < 3) ? m_btb[i].ctr + 1 : 3) : 3;
      m_btb[i].valid  = 1'b1;
      m_btb[i].tag    = m_tag(upd_pc);
      m_btb[i].target = pc_jump;
      m_btb[i].kind   = k;
    end else if (hit && m_btb[i].ctr > 0) begin
      m_btb[i].ctr = m_btb[i].ctr - 1;
    end
    if (cflow_hint == CFHINT_CALL) begin
      m_ras.push_back(upd_pc + 32'd4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (cflow_hint == CFHINT_RET && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
    m_branches++;
    if (mispredict) m_mispredicts++;
  endfunction

  // One clock: drive inputs, compare mid-cycle against the model, then advance both.
  task automatic cyc(input logic [31:0] ipc, input cflow_mode_t m, input cflow_hint_t h,
                     input logic tk, input logic [31:0] upc, input logic [31:0] pj,
                     input logic mp, input logic r);
    bit        e_tk;
    bit [31:0] e_pc;
    if_pc = ipc; cflow_mode = m; cflow_hint = h; cflow_taken = tk;
    upd_pc = upc; pc_jump = pj; mispredict = mp; rst = r;
    #4;
    m_predict(ipc, e_tk, e_pc);
    check("pred_taken", 32'(pred_taken), 32'(e_tk));
    check("pc_pred", pc_pred, e_pc);
    check("perf_branches", perf_branches, m_branches);
    check("perf_mispredicts", perf_mispredicts, m_mispredicts);
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(ipc, CFLOW_PCPLUS4, CFHINT_NONE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic br(input logic [31:0] upc, input logic tk, input logic [31:0] pj);
    cyc(32'h0, CFLOW_BRANCH, CFHINT_NONE, tk, upc, pj, 1'b0, 1'b0);
  endtask

  task automatic call(input logic [31:0] upc, input logic [31:0] pj);
    cyc(32'h0, CFLOW_JAL, CFHINT_CALL, 1'b1, upc, pj, 1'b0, 1'b0);
  endtask

  task automatic ret(input logic [31:0] upc, input logic [31:0] pj);
    cyc(32'h0, CFLOW_JALR, CFHINT_RET, 1'b1, upc, pj, 1'b0, 1'b0);
  endtask

  // Literal expectations taken straight from the intended behaviour.
  task automatic expect_pred(input string tag, input logic [31:0] ipc,
                             input logic e_tk, input logic [31:0] e_pc);
    if_pc = ipc; cflow_mode = CFLOW_PCPLUS4; cflow_hint = CFHINT_NONE; rst = 1'b0;
    #4;
    check({tag, "_taken"}, 32'(pred_taken), 32'(e_tk));
    check({tag, "_pc"}, pc_pred, e_pc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_pc = 32'h100; cflow_mode = CFLOW_PCPLUS4; cflow_hint = CFHINT_NONE; cflow_taken = 1'b0;
    upd_pc = '0; pc_jump = '0; mispredict = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    m_reset();
    #1;

    // Reset state
    expect_pred("reset", 32'h100, 1'b0, 32'h104);
    check("reset_perf_br", perf_branches, 32'h0);
    check("reset_perf_mp", perf_mispredicts, 32'h0);

    // Branch counter training and saturation
    br(32'h100, 1'b1, 32'h80);
    expect_pred("br_alloc", 32'h100, 1'b1, 32'h80);
    br(32'h100, 1'b0, 32'h0);
    br(32'h100, 1'b0, 32'h0);
    expect_pred("br_ctr00", 32'h100, 1'b0, 32'h104);
    br(32'h100, 1'b0, 32'h0);
    br(32'h100, 1'b1, 32'h80);
    expect_pred("br_ctr01", 32'h100, 1'b0, 32'h104);
    repeat (3) br(32'h100, 1'b1, 32'h80);
    br(32'h100, 1'b0, 32'h0);
    expect_pred("br_sat11", 32'h100, 1'b1, 32'h80);

    // Call / return through the RAS
    call(32'h200, 32'h400);
    ret(32'h404, 32'h204);
    expect_pred("ret_empty", 32'h404, 1'b0, 32'h408);
    call(32'h200, 32'h400);
    expect_pred("ret_ras", 32'h404, 1'b1, 32'h204);
    ret(32'h404, 32'h204);

    // RAS overflow: nine calls, oldest lost, then drain past empty
    for (int k = 0; k < 9; k++) call(32'h1000 + 32'(k * 16), 32'h3000);
    for (int k = 0; k < 9; k++) begin
      idle(32'h404);
      ret(32'h404, 32'h0);
    end
    expect_pred("ras_drained", 32'h404, 1'b0, 32'h408);
    ret(32'h404, 32'h0);
    call(32'h200, 32'h400);
    expect_pred("pop_empty_ignored", 32'h404, 1'b1, 32'h204);
    ret(32'h404, 32'h204);

    // Aliasing: second PC evicts the first from the shared slot
    br(32'h140, 1'b1, 32'h90);
    br(32'h140 + 4 * BTB_ENTRIES, 1'b1, 32'ha0);
    expect_pred("alias_new", 32'h140 + 4 * BTB_ENTRIES, 1'b1, 32'ha0);
    expect_pred("alias_old", 32'h140, 1'b0, 32'h144);

    // Same-cycle update and lookup sees the old state
    cyc(32'h300, CFLOW_BRANCH, CFHINT_NONE, 1'b1, 32'h300, 32'h500, 1'b0, 1'b0);
    expect_pred("after_bypass", 32'h300, 1'b1, 32'h500);

    // Reset during an update drops the write
    cyc(32'h600, CFLOW_JAL, CFHINT_CALL, 1'b1, 32'h600, 32'h700, 1'b1, 1'b1);
    expect_pred("rst_drop", 32'h600, 1'b0, 32'h604);
    expect_pred("rst_clear", 32'h300, 1'b0, 32'h304);
    check("rst_perf_br", perf_branches, 32'h0);

    // Perf counters: 5 updates, 2 mispredicts
    for (int k = 0; k < 5; k++)
      cyc(32'h0, CFLOW_BRANCH, CFHINT_NONE, 1'(k % 2), 32'h800 + 32'(4 * k), 32'h900, 1'(k < 2), 1'b0);
    idle(32'h0);
    check("perf_br5", perf_branches, 32'd5);
    check("perf_mp2", perf_mispredicts, 32'd2);

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ipc, upc, pj;
      cflow_mode_t m;
      cflow_hint_t h;
      logic        tk;
      ipc = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'(4 * BTB_ENTRIES * $urandom_range(0, 1));
      upc = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'(4 * BTB_ENTRIES * $urandom_range(0, 1));
      pj  = $urandom & 32'hffff_fffe;
      m   = cflow_mode_t'($urandom_range(0, 3));
      tk  = 1'($urandom_range(0, 1));
      h   = CFHINT_NONE;
      if (m == CFLOW_JAL) begin
        tk = 1'b1;
        if ($urandom_range(0, 1) == 1) h = CFHINT_CALL;
      end else if (m == CFLOW_JALR) begin
        h = cflow_hint_t'($urandom_range(0, 2));
        if ($urandom_range(0, 7) != 0) tk = 1'b1;
      end
      cyc(ipc, m, h, tk, upc, pj, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
